// File: rtl/descriptor_fetcher.sv
// Avalon-MM master that walks a linked list of 8-word DMA descriptors, hands each
// one to the transfer engine and writes back completion status before following next.
module descriptor_fetcher #(
  parameter int ADDR_W  = 32,
  parameter int OWN_BIT = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic              stop,
  output logic              busy,
  output logic              chain_end,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  output logic [7:0]        desc_ctrl,
  input  logic              xfer_done,
  input  logic [7:0]        xfer_status,
  input  logic [15:0]       xfer_bytes
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, CHECK, PRESENT, WAIT_DONE, WB, NEXT
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] cur_ptr_r;
  logic [ADDR_W-1:0] next_ptr_r;
  logic [2:0]        idx_r;
  logic              own_r;
  logic [ADDR_W-1:0] head_aligned_s;
  logic [ADDR_W-1:0] rd_addr_next_s;

  // Status word written over word 7; the ownership bit is handed back to software.
  function automatic logic [31:0] wb_word(input logic [7:0] ctrl, input logic [7:0] status,
                                          input logic [15:0] bytes);
    logic [31:0] tmp;
    tmp = {ctrl, status, bytes};
    tmp[OWN_BIT] = (OWN_BIT >= 32'sd24) ? 1'b0 : tmp[OWN_BIT];
    return tmp;
  endfunction

  assign head_aligned_s = head_ptr & ~ADDR_W'(5'h1F);
  assign rd_addr_next_s = cur_ptr_r + ADDR_W'({idx_r + 3'd1, 2'b00});
  assign m_byteenable   = 4'hF;

  // Walk sequencer: one outstanding bus access at a time, every output registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cur_ptr_r   <= {ADDR_W{1'b0}};
      next_ptr_r  <= {ADDR_W{1'b0}};
      idx_r       <= 3'd0;
      own_r       <= 1'b0;
      busy        <= 1'b0;
      chain_end   <= 1'b0;
      m_address   <= {ADDR_W{1'b0}};
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= 32'h0000_0000;
      desc_valid  <= 1'b0;
      desc_src    <= 32'h0000_0000;
      desc_dst    <= 32'h0000_0000;
      desc_len    <= 16'h0000;
      desc_ctrl   <= 8'h00;
    end else begin
      chain_end <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cur_ptr_r <= head_aligned_s;
            m_address <= head_aligned_s;
            idx_r     <= 3'd0;
            m_read    <= 1'b1;
            busy      <= 1'b1;
            state_r   <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (!m_waitrequest) begin
            m_read  <= 1'b0;
            state_r <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (m_readdatavalid) begin
            case (idx_r)
              3'd0:    desc_src   <= m_readdata;
              3'd2:    desc_dst   <= m_readdata;
              3'd4:    next_ptr_r <= ADDR_W'(m_readdata);
              3'd6:    desc_len   <= m_readdata[15:0];
              3'd7: begin
                desc_ctrl <= m_readdata[31:24];
                own_r     <= m_readdata[OWN_BIT];
              end
              default: ;
            endcase
            if (idx_r == 3'd7) begin
              state_r <= CHECK;
            end else begin
              idx_r     <= idx_r + 3'd1;
              m_address <= rd_addr_next_s;
              m_read    <= 1'b1;
              state_r   <= RD_REQ;
            end
          end
        end
        CHECK: begin
          if (own_r) begin
            desc_valid <= 1'b1;
            state_r    <= PRESENT;
          end else begin
            busy      <= 1'b0;
            chain_end <= 1'b1;
            state_r   <= IDLE;
          end
        end
        PRESENT: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            state_r    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (xfer_done) begin
            m_write     <= 1'b1;
            m_address   <= cur_ptr_r + ADDR_W'(5'd28);
            m_writedata <= wb_word(desc_ctrl, xfer_status, xfer_bytes);
            state_r     <= WB;
          end
        end
        WB: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            state_r <= NEXT;
          end
        end
        NEXT: begin
          // A zero or self-referencing next pointer terminates the chain.
          if (stop || (next_ptr_r == {ADDR_W{1'b0}}) || (next_ptr_r == cur_ptr_r)) begin
            busy      <= 1'b0;
            chain_end <= 1'b1;
            state_r   <= IDLE;
          end else begin
            cur_ptr_r <= next_ptr_r;
            m_address <= next_ptr_r;
            idx_r     <= 3'd0;
            m_read    <= 1'b1;
            state_r   <= RD_REQ;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_descriptor_fetcher.sv
// Bench for descriptor_fetcher: behavioural Avalon slave and descriptor consumer driven
// at the falling edge, with queues of expected reads, descriptors and writebacks.
`timescale 1ns/1ps
module tb_descriptor_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] head_ptr = 32'h0;
  logic        stop = 1'b0;
  logic        busy, chain_end, m_read, m_write, desc_valid;
  logic [31:0] m_address, m_writedata, desc_src, desc_dst;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = 32'h0;
  logic        m_readdatavalid = 1'b0;
  logic        desc_ready = 1'b0;
  logic [15:0] desc_len;
  logic [7:0]  desc_ctrl;
  logic        xfer_done = 1'b0;
  logic [7:0]  xfer_status = 8'h0;
  logic [15:0] xfer_bytes = 16'h0;

  always #5 clk = ~clk;

  descriptor_fetcher #(.ADDR_W(32), .OWN_BIT(31)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .head_ptr(head_ptr), .stop(stop),
    .busy(busy), .chain_end(chain_end), .m_address(m_address), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_ctrl(desc_ctrl),
    .xfer_done(xfer_done), .xfer_status(xfer_status), .xfer_bytes(xfer_bytes)
  );

  logic [31:0] mem [0:63];
  logic [31:0] exp_rd_q [$];
  logic [63:0] exp_wr_q [$];
  logic [87:0] exp_desc_q [$];
  logic [23:0] done_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_mode = 1'b0;
  int hold_cycles = 0;
  int stop_idx = -1;
  bit rd_pending = 1'b0;
  int rd_cnt = 0;
  logic [31:0] rd_addr = 32'h0;
  bit stalled = 1'b0;
  logic stall_rd = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  int hold_cnt = 0;
  int done_cnt = -1;
  logic [23:0] done_val = 24'h0;
  int desc_cnt = 0;
  int reads_seen = 0;
  int start_edge = 0;
  int last_rdv_edge = 0;
  int chain_edge = 0;
  int dv_edge = 0;
  bit dv_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_desc(input logic [31:0] base, input logic [31:0] w7, input logic [31:0] nxt);
    for (int i = 0; i < 8; i++)
      mem[base[7:2] + 6'(i)] = {8'hA0 + 8'(i), base[7:0], 16'h5500 + 16'(i)};
    mem[base[7:2] + 6'd4] = nxt;
    mem[base[7:2] + 6'd7] = w7;
  endtask

  task automatic put_chain3();
    put_desc(32'h00, 32'h8300_0000, 32'h20);
    put_desc(32'h20, 32'hC100_0000, 32'h40);
    put_desc(32'h40, 32'h8A00_1234, 32'h00);
  endtask

  // Reference walk of the list as held in mem; fills the scoreboard queues.
  task automatic expect_chain(input logic [31:0] head, input int stop_at);
    logic [31:0] ptr, w7, nxt;
    logic [7:0]  st;
    logic [15:0] by;
    int k;
    ptr = head & 32'hFFFF_FFE0;
    k = 0;
    while (k < 8) begin
      for (int i = 0; i < 8; i++) exp_rd_q.push_back(ptr + 32'(4 * i));
      w7 = mem[ptr[7:2] + 6'd7];
      if (!w7[31]) break;
      exp_desc_q.push_back({mem[ptr[7:2]], mem[ptr[7:2] + 6'd2],
                            mem[ptr[7:2] + 6'd6][15:0], w7[31:24]});
      st = 8'h01 + 8'(k);
      by = 16'h0100 + 16'(k * 16);
      done_q.push_back({st, by});
      exp_wr_q.push_back({ptr + 32'd28, 1'b0, w7[30:24], st, by});
      if (k == stop_at) break;
      nxt = mem[ptr[7:2] + 6'd4];
      if (nxt == 32'd0 || nxt == ptr) break;
      ptr = nxt;
      k++;
    end
  endtask

  // Slave + consumer behaviour for one falling edge.
  task automatic model();
    if (stalled) begin
      check_eq("stall_hold", {m_read, m_write, m_address}, {stall_rd, ~stall_rd, stall_addr});
      stalled = 1'b0;
    end
    m_readdatavalid = 1'b0;
    m_readdata = 32'hBAD0_BAD0;
    if (rd_pending) begin
      if (rd_cnt == 0) begin
        m_readdatavalid = 1'b1;
        m_readdata = mem[rd_addr[7:2]];
        rd_pending = 1'b0;
        last_rdv_edge = cyc + 1;
      end else begin
        rd_cnt--;
      end
    end
    m_waitrequest = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
    if (m_read || m_write) check_eq("rw_excl", m_read & m_write, 1'b0);
    if (m_read) begin
      if (m_waitrequest) begin
        stalled = 1'b1; stall_rd = 1'b1; stall_addr = m_address;
      end else begin
        reads_seen++;
        if (exp_rd_q.size() == 0) check_eq("rd_unexpected", m_read, 1'b0);
        else check_eq("rd_addr", m_address, exp_rd_q.pop_front());
        rd_pending = 1'b1;
        rd_addr = m_address;
        rd_cnt = rand_mode ? int'($urandom_range(0, 3)) : 0;
      end
    end
    if (m_write) begin
      if (m_waitrequest) begin
        stalled = 1'b1; stall_rd = 1'b0; stall_addr = m_address;
      end else begin
        if (exp_wr_q.size() == 0) check_eq("wr_unexpected", m_write, 1'b0);
        else check_eq("wr", {m_address, m_writedata}, exp_wr_q.pop_front());
        mem[m_address[7:2]] = m_writedata;
      end
    end
    xfer_done = 1'b0;
    if (done_cnt == 0) begin
      xfer_done = 1'b1;
      {xfer_status, xfer_bytes} = done_val;
      if (desc_cnt - 1 == stop_idx) stop = 1'b1;
      done_cnt = -1;
    end else if (done_cnt > 0) begin
      done_cnt--;
    end
    if (desc_valid && !dv_seen) begin
      dv_seen = 1'b1;
      dv_edge = cyc;
    end
    desc_ready = 1'b0;
    if (desc_valid) begin
      if (exp_desc_q.size() == 0) begin
        check_eq("desc_unexpected", desc_valid, 1'b0);
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        check_eq("desc_hold", {desc_src, desc_dst, desc_len, desc_ctrl}, exp_desc_q[0]);
      end else begin
        desc_ready = 1'b1;
        check_eq("desc", {desc_src, desc_dst, desc_len, desc_ctrl}, exp_desc_q.pop_front());
        done_val = (done_q.size() != 0) ? done_q.pop_front() : 24'h0;
        done_cnt = 2;
        desc_cnt++;
        hold_cnt = hold_cycles;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ctl"}, {busy, chain_end, m_read, m_write, desc_valid}, 5'b00000);
    check_eq({tag, "_bus"}, {m_address, m_writedata}, 64'h0);
    check_eq({tag, "_desc"}, {desc_src, desc_dst, desc_len, desc_ctrl}, 88'h0);
  endtask

  task automatic clear_model();
    rd_pending = 1'b0; stalled = 1'b0; done_cnt = -1; stop = 1'b0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0; desc_ready = 1'b0; xfer_done = 1'b0;
    exp_rd_q.delete(); exp_wr_q.delete(); exp_desc_q.delete(); done_q.delete();
  endtask

  task automatic run_walk(input logic [31:0] head, input int stop_at, input string tag);
    int guard, n_reads;
    expect_chain(head, stop_at);
    n_reads = exp_rd_q.size();
    hold_cnt = hold_cycles; desc_cnt = 0; stop_idx = stop_at; reads_seen = 0; dv_seen = 1'b0;
    @(negedge clk);
    model();
    start = 1'b1;
    head_ptr = head;
    start_edge = cyc + 1;
    guard = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      model();
      guard++;
    end while (!chain_end && guard < 2000);
    chain_edge = cyc;
    check_eq({tag, "_chain_end"}, chain_end, 1'b1);
    @(negedge clk);
    model();
    check_eq({tag, "_idle"}, {chain_end, busy}, 2'b00);
    check_eq({tag, "_nreads"}, reads_seen, n_reads);
    check_eq({tag, "_left"}, {exp_rd_q.size(), exp_wr_q.size(), exp_desc_q.size()}, 96'h0);
    stop = 1'b0;
  endtask

  task automatic abort_walk(input logic [31:0] head, input bit in_wb, input string tag);
    int guard;
    bit hit;
    expect_chain(head, -1);
    hold_cnt = 0; desc_cnt = 0; stop_idx = -1; reads_seen = 0;
    @(negedge clk);
    model();
    start = 1'b1;
    head_ptr = head;
    guard = 0;
    hit = 1'b0;
    while (guard < 500) begin
      @(negedge clk);
      start = 1'b0;
      if (in_wb ? m_write : (busy && !m_read && rd_pending && reads_seen >= 3)) begin
        hit = 1'b1;
        break;
      end
      model();
      guard++;
    end
    check_eq({tag, "_reached"}, hit, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_vals(tag);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    check_eq("byteenable", m_byteenable, 4'hF);
    reset_n = 1'b1;

    put_desc(32'h40, 32'h8000_0000, 32'h0);
    run_walk(32'h40, -1, "single");
    check_eq("single_dv_latency", dv_edge - start_edge, 32'd17);
    check_eq("single_wbmem", mem[6'h17], 32'h0001_0100);

    put_chain3();
    run_walk(32'h00, -1, "chain3");

    put_desc(32'h80, 32'h7F00_0000, 32'hA0);
    run_walk(32'h80, -1, "notown");
    check_eq("notown_dv", dv_seen, 1'b0);
    check_eq("notown_end_latency", chain_edge - last_rdv_edge, 32'd1);

    put_chain3();
    rand_mode = 1'b1;
    run_walk(32'h00, -1, "rand");
    rand_mode = 1'b0;

    put_chain3();
    hold_cycles = 10;
    run_walk(32'h00, 0, "stop");
    hold_cycles = 0;

    put_chain3();
    abort_walk(32'h00, 1'b0, "rst_rdwait");
    put_desc(32'h60, 32'h8500_0000, 32'h0);
    run_walk(32'h6B, -1, "after_rst1");

    put_chain3();
    abort_walk(32'h00, 1'b1, "rst_wb");
    put_desc(32'h60, 32'h8500_0000, 32'h0);
    run_walk(32'h6B, -1, "after_rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
